// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO through its read port and serialises each byte
// as a UART frame (start, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits).
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              empty,
    output logic              r_en,
    input  logic [DATA_W-1:0] r_data,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 2);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_PARITY = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   baud_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shift_reg;
    logic               parity_bit;
    logic               bit_end;
    logic               frame_end;
    logic               tx_next;

    assign bit_end   = (baud_cnt == LAST_CNT);
    assign frame_end = (state == STOP) && bit_end && (bit_idx == LAST_STOP);

    assign r_en = (state == FETCH);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (en && !empty) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                next_state = LOAD;
            end
            LOAD: begin
                next_state = START;
            end
            START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (bit_end && (bit_idx == LAST_DATA)) begin
                    next_state = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_next = parity_bit;
                if (bit_end) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                // Back-to-back frames go straight to FETCH, leaving two idle-high cycles.
                if (frame_end) begin
                    next_state = (en && !empty) ? FETCH : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // tx and byte_done are registered, so the line lags the state by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx         <= 1'b1;
            byte_done  <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            tx        <= tx_next;
            byte_done <= frame_end;

            if (state == START || state == DATA || state == PARITY || state == STOP) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
            end

            if (next_state != state) begin
                bit_idx <= '0;
            end else if (bit_end && (state == DATA || state == STOP)) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (state == LOAD) begin
                shift_reg  <= r_data;
                parity_bit <= (^r_data) ^ ODD_PARITY;
            end else if (state == DATA && bit_end) begin
                shift_reg <= shift_reg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four instances with different frame formats share one FIFO model;
// a scoreboard checks every frame seen on the selected line against a behavioural frame model.
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int NDUT = 4;
    localparam int CFG_PAR  [NDUT] = '{0, 1, 1, 0};
    localparam int CFG_ODD  [NDUT] = '{0, 0, 1, 0};
    localparam int CFG_STOP [NDUT] = '{1, 1, 1, 2};

    typedef struct {
        int         sel;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         exp_len;
        int         chk_par;
        logic       exp_par;
    } vec_t;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            empty = 1'b1;
    logic [NDUT-1:0] en_w  = '0;
    logic [7:0]      r_data = '0;
    wire  [NDUT-1:0] ren_w;
    wire  [NDUT-1:0] tx_w;
    wire  [NDUT-1:0] busy_w;
    wire  [NDUT-1:0] bd_w;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fifo_q [$];
    exp_t        exp_q [$];
    int          gap_q [$];
    int          sel = 0;
    int          mon_cnt = 0;
    int          frames_done = 0;
    int          idle_run = 0;
    int          obs_len = 0;
    logic        obs_par = 1'b0;
    logic [63:0] line_bits = '1;
    logic [63:0] done_bits = '0;
    int          ren_cnt [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fifo_uart_tx #(
            .DATA_W      (8),
            .CLKS_PER_BIT(CPB),
            .STOP_BITS   (CFG_STOP[g]),
            .PARITY_EN   (CFG_PAR[g]),
            .PARITY_ODD  (CFG_ODD[g])
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .en       (en_w[g]),
            .empty    (empty),
            .r_en     (ren_w[g]),
            .r_data   (r_data),
            .tx       (tx_w[g]),
            .busy     (busy_w[g]),
            .byte_done(bd_w[g])
        );
    end

    // FIFO model: read data appears the cycle after the strobe; empty settles on the falling edge.
    always @(posedge clk) begin
        if (|ren_w && fifo_q.size() > 0) begin
            r_data <= fifo_q.pop_front();
        end
    end

    always @(negedge clk) begin
        empty = (fifo_q.size() == 0);
        for (int i = 0; i < NDUT; i++) begin
            if (ren_w[i]) ren_cnt[i]++;
        end
    end

    function automatic int frame_len(input int s);
        return (1 + 8 + CFG_PAR[s] + CFG_STOP[s]) * CPB;
    endfunction

    function automatic logic [63:0] expect_line(input int s, input logic [7:0] d);
        logic [63:0] v;
        logic        p;
        logic        bv;
        int          nb;
        v  = '1;
        nb = 1 + 8 + CFG_PAR[s] + CFG_STOP[s];
        p  = (^d) ^ (CFG_ODD[s] != 0);
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                          bv = 1'b0;
            else if (b <= 8)                     bv = d[b-1];
            else if (CFG_PAR[s] != 0 && b == 9)  bv = p;
            else                                 bv = 1'b1;
            for (int c = 0; c < CPB; c++) v[b*CPB + c] = bv;
        end
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input int s, input logic [7:0] d);
        exp_t e;
        e.sel  = s;
        e.data = d;
        fifo_q.push_back(d);
        exp_q.push_back(e);
        empty = 1'b0;
    endtask

    task automatic score_frame();
        exp_t e;
        int   flen;
        flen    = frame_len(sel);
        obs_len = 0;
        for (int i = flen - 1; i >= 0; i--) begin
            if (done_bits[i]) obs_len = i + 1;
        end
        obs_par = line_bits[9*CPB + CPB/2];
        check_output("sb_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("sb_dut_sel", 64'(sel), 64'(e.sel));
            check_output("sb_frame_bits", line_bits, expect_line(e.sel, e.data));
            check_output("sb_byte_done", done_bits, 64'd1 << (flen - 1));
        end
        frames_done++;
    endtask

    // Line monitor: captures one sample per cycle from the falling start edge to the last stop cycle.
    always @(negedge clk) begin
        if (!rst) begin
            mon_cnt = 0;
        end else if (mon_cnt == 0) begin
            if (tx_w[sel] == 1'b0) begin
                gap_q.push_back(idle_run);
                idle_run     = 0;
                line_bits    = '1;
                done_bits    = '0;
                line_bits[0] = 1'b0;
                done_bits[0] = bd_w[sel];
                mon_cnt      = 1;
            end else begin
                idle_run++;
            end
        end else begin
            line_bits[mon_cnt] = tx_w[sel];
            done_bits[mon_cnt] = bd_w[sel];
            mon_cnt++;
            if (mon_cnt == frame_len(sel)) begin
                score_frame();
                mon_cnt = 0;
            end
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("frame_timeout", 64'(frames_done >= target), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_mon(input int min_cnt, input int budget);
        int n;
        n = 0;
        while (mon_cnt < min_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("mon_reach", 64'(mon_cnt >= min_cnt), 64'd1);
    endtask

    task automatic check_latency(input int s, input string tag);
        @(posedge clk);
        @(negedge clk);
        check_output({tag, "_k0_tx"}, 64'(tx_w[s]), 64'd1);
        check_output({tag, "_k0_ren"}, 64'(ren_w[s]), 64'd1);
        @(negedge clk);
        check_output({tag, "_k1_tx"}, 64'(tx_w[s]), 64'd1);
        check_output({tag, "_k1_ren"}, 64'(ren_w[s]), 64'd0);
        @(negedge clk);
        check_output({tag, "_k2_tx"}, 64'(tx_w[s]), 64'd1);
        @(negedge clk);
        check_output({tag, "_k3_tx"}, 64'(tx_w[s]), 64'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [8];
        exp_t lost;
        int   base, r0, viol, n, done_cnt, drops, started;

        vecs[0] = '{sel: 0, data: 8'hA5, exp_len: 40, chk_par: 0, exp_par: 1'b0};
        vecs[1] = '{sel: 1, data: 8'hA5, exp_len: 44, chk_par: 1, exp_par: 1'b0};
        vecs[2] = '{sel: 2, data: 8'hA5, exp_len: 44, chk_par: 1, exp_par: 1'b1};
        vecs[3] = '{sel: 1, data: 8'h01, exp_len: 44, chk_par: 1, exp_par: 1'b1};
        vecs[4] = '{sel: 2, data: 8'h00, exp_len: 44, chk_par: 1, exp_par: 1'b1};
        vecs[5] = '{sel: 1, data: 8'hFF, exp_len: 44, chk_par: 1, exp_par: 1'b0};
        vecs[6] = '{sel: 3, data: 8'hA5, exp_len: 44, chk_par: 0, exp_par: 1'b0};
        vecs[7] = '{sel: 0, data: 8'h3C, exp_len: 40, chk_par: 0, exp_par: 1'b0};

        // Reset state, then idle with the FIFO empty.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_tx", 64'(tx_w), 64'hF);
        check_output("reset_busy", 64'(busy_w), 64'h0);
        check_output("reset_ren", 64'(ren_w), 64'h0);
        check_output("reset_byte_done", 64'(bd_w), 64'h0);
        rst  = 1'b1;
        en_w = '1;
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_w != 4'hF || ren_w != 4'h0 || busy_w != 4'h0 || bd_w != 4'h0) viol++;
        end
        check_output("idle_empty_violations", 64'(viol), 64'd0);
        en_w = '0;

        // Single byte with latency from empty low to tx falling.
        sel  = 0;
        en_w = 4'b0001;
        base = frames_done;
        r0   = ren_cnt[0];
        @(negedge clk);
        #1 push_byte(0, 8'hA5);
        check_latency(0, "single");
        wait_frames(base + 1, 200);
        check_output("single_ren_pulses", 64'(ren_cnt[0] - r0), 64'd1);
        check_output("single_len", 64'(obs_len), 64'd40);

        // Table of single frames across formats.
        for (int i = 0; i < 8; i++) begin
            sel  = vecs[i].sel;
            en_w = '0;
            en_w[vecs[i].sel] = 1'b1;
            base = frames_done;
            @(negedge clk);
            #1 push_byte(vecs[i].sel, vecs[i].data);
            wait_frames(base + 1, 300);
            check_output($sformatf("vec%0d_len", i), 64'(obs_len), 64'(vecs[i].exp_len));
            if (vecs[i].chk_par != 0) begin
                check_output($sformatf("vec%0d_parity", i), 64'(obs_par), 64'(vecs[i].exp_par));
            end
        end
        en_w = '0;

        // Back-to-back burst of three bytes.
        sel  = 0;
        en_w = 4'b0001;
        base = frames_done;
        r0   = ren_cnt[0];
        gap_q.delete();
        @(negedge clk);
        #1;
        push_byte(0, 8'h00);
        push_byte(0, 8'hFF);
        push_byte(0, 8'h3C);
        done_cnt = 0;
        drops    = 0;
        started  = 0;
        n        = 0;
        while (done_cnt < 3 && n < 600) begin
            @(negedge clk);
            n++;
            if (bd_w[0]) done_cnt++;
            if (done_cnt < 3) begin
                if (busy_w[0]) started = 1;
                else if (started != 0) drops++;
            end
        end
        check_output("b2b_byte_done_count", 64'(done_cnt), 64'd3);
        check_output("b2b_busy_drops", 64'(drops), 64'd0);
        wait_frames(base + 3, 100);
        check_output("b2b_ren_pulses", 64'(ren_cnt[0] - r0), 64'd3);
        check_output("b2b_gap_count", 64'(gap_q.size()), 64'd3);
        if (gap_q.size() == 3) begin
            check_output("b2b_gap1", 64'(gap_q[1]), 64'd2);
            check_output("b2b_gap2", 64'(gap_q[2]), 64'd2);
        end

        // Two stop bits, enable dropped during the first frame's data bits.
        sel  = 3;
        en_w = 4'b1000;
        base = frames_done;
        r0   = ren_cnt[3];
        @(negedge clk);
        #1;
        push_byte(3, 8'h5A);
        push_byte(3, 8'hC3);
        wait_mon(3 * CPB, 100);
        en_w[3] = 1'b0;
        wait_frames(base + 1, 200);
        check_output("stop2_len", 64'(obs_len), 64'd44);
        repeat (20) @(negedge clk);
        check_output("en_drop_ren_pulses", 64'(ren_cnt[3] - r0), 64'd1);
        check_output("en_drop_busy", 64'(busy_w[3]), 64'd0);
        check_output("en_drop_frames", 64'(frames_done - base), 64'd1);
        @(negedge clk);
        #1 en_w[3] = 1'b1;
        check_latency(3, "en_resume");
        wait_frames(base + 2, 200);
        check_output("en_resume_ren_pulses", 64'(ren_cnt[3] - r0), 64'd2);
        en_w = '0;

        // Asynchronous reset in the middle of a frame.
        sel  = 0;
        en_w = 4'b0001;
        base = frames_done;
        r0   = ren_cnt[0];
        @(negedge clk);
        #1;
        push_byte(0, 8'h96);
        push_byte(0, 8'h69);
        wait_mon(4 * CPB, 100);
        #1 rst = 1'b0;
        #1;
        check_output("midrst_tx", 64'(tx_w[0]), 64'd1);
        check_output("midrst_busy", 64'(busy_w[0]), 64'd0);
        check_output("midrst_pending", 64'(exp_q.size()), 64'd2);
        if (exp_q.size() > 0) lost = exp_q.pop_front();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        wait_frames(base + 1, 200);
        check_output("midrst_ren_pulses", 64'(ren_cnt[0] - r0), 64'd2);
        check_output("midrst_sb_drained", 64'(exp_q.size()), 64'd0);
        en_w = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
